// File: rtl/sr_vr_pkg.sv
// rtl/sr_vr_pkg.sv - shared helpers for the valid/ready shift register
package sr_vr_pkg;

  // Occupancy counter must hold every value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vr_stage.sv
// rtl/vr_stage.sv - one elastic pipeline stage: valid flag plus payload register
module vr_stage #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             up_vld,
  input  logic [width-1:0] up_data,
  output logic             vld,
  output logic [width-1:0] data
);

  // Valid flag: cleared by reset or flush; on load it takes whatever the upstream offers,
  // so a bubble moves in when upstream is empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= up_vld;
    end
  end

  // Payload: only captured when a real item moves in, so a bubble never overwrites data.
  always_ff @(posedge clk) begin
    if (load && up_vld) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/shift_register_with_valid_ready.sv
// rtl/shift_register_with_valid_ready.sv - elastic depth-stage delay line with valid/ready on both sides
module shift_register_with_valid_ready
  import sr_vr_pkg::*;
#(
  parameter  int width = 8,
  parameter  int depth = 8,
  localparam int cnt_w = cnt_width(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [width-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [width-1:0] out_data,
  output logic [cnt_w-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [depth-1:0] vld;
  logic [depth-1:0] load;
  logic [width-1:0] data [depth];
  logic             chain;
  logic             in_fire;
  logic             out_fire;

  // Ready ripples from the output back to stage 0: a stage can load when it is empty
  // or its item leaves this cycle (load = ~vld | downstream ready).
  always_comb begin
    load  = '0;
    chain = out_rdy;
    for (int k = depth - 1; k >= 0; k--) begin
      load[k] = ~vld[k] | chain;
      chain   = load[k];
    end
  end

  for (genvar k = 0; k < depth; k++) begin : g_stage
    logic             up_vld_k;
    logic [width-1:0] up_data_k;

    if (k == 0) begin : g_head
      // Flush blocks acceptance, so the head only sees a valid input on a true handshake.
      assign up_vld_k  = in_vld & ~flush;
      assign up_data_k = in_data;
    end else begin : g_body
      assign up_vld_k  = vld[k-1];
      assign up_data_k = data[k-1];
    end

    vr_stage #(
      .width(width)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (load[k]),
      .up_vld  (up_vld_k),
      .up_data (up_data_k),
      .vld     (vld[k]),
      .data    (data[k])
    );
  end

  assign in_rdy   = load[0] & ~flush;
  assign out_vld  = vld[depth-1];
  assign out_data = data[depth-1];

  assign in_fire  = in_vld & in_rdy;
  assign out_fire = out_vld & out_rdy;

  // Occupancy tracks handshakes rather than summing vld, keeping flags off the ripple path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + cnt_w'(1);
    end else if (out_fire && !in_fire) begin
      count <= count - cnt_w'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == cnt_w'(depth));

endmodule

// File: doc/shift_register_with_valid_ready.md
Name: shift_register_with_valid_ready

Overview:
- Parametrised successor of the valid-gated shift register: a depth-stage data delay line with a full valid/ready handshake on both sides.
- Stages advance independently, so bubbles collapse and data compacts under downstream backpressure.
- Adds occupancy count, full/empty flags and a synchronous flush.
- Used as an elastic, latency-matching pipe next to arithmetic pipelines such as the sqrt-formula pipes, which must absorb stalls.

Parameters:
width, 8, data bits per transfer
depth, 8, number of pipeline stages (legal range 1 and up)
cnt_w, $clog2(depth+1), occupancy counter width (localparam, not overridable)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of all stages; no reset of data
in_vld  in  1  upstream transfer valid
in_rdy  out  1  block can accept this cycle
in_data  in  width  upstream payload
out_vld  out  1  stage depth-1 holds valid data
out_rdy  in  1  downstream accepts this cycle
out_data  out  width  payload of stage depth-1; don't-care when out_vld=0
count  out  cnt_w  number of valid stages
empty  out  1  count == 0
full  out  1  count == depth

Behaviour:
- State: vld[0..depth-1] (reset), data[0..depth-1] (no reset). Stage k feeds stage k+1. Outputs are driven from stage depth-1.
- Move and load terms:
  - Last stage: move[depth-1] = vld[depth-1] & out_rdy.
  - Other stages: move[k] = vld[k] & (~vld[k+1] | move[k+1]).
  - load[k] = ~vld[k] | move[k].
- in_rdy = load[0] & ~flush. This is a combinational path from out_rdy to in_rdy, accepted by design. The ripple chain length is depth.
- Accept: an input handshake is in_vld & in_rdy. On it, data[0] <= in_data and vld[0] <= 1.
- Stage 0 update: if load[0] and no handshake, vld[0] <= 0.
- Stage k>0 update: if load[k], then vld[k] <= vld[k-1] and data[k] <= data[k-1]. data[k] is written only when vld[k-1]=1.
- Output handshake: out_vld & out_rdy.
- Latency: exactly depth cycles from an accept to out_vld with no stall. Throughput is 1 per cycle with out_rdy held at 1.
- Stall: with out_rdy=0 the pipe compacts toward the output. in_rdy drops only when all depth stages are valid and stage 0 cannot move.
- Simultaneous input and output handshake when full: allowed in the same cycle. count is unchanged.
- count is a registered up/down counter:
  - +1 on input handshake; -1 on output handshake; unchanged when both or neither occur.
  - It must always equal the popcount of vld[].
  - empty and full are decoded from count.
- flush=1:
  - Next edge: all vld <= 0 and count <= 0.
  - in_rdy=0 that cycle, so no input is accepted.
  - An output handshake in the flush cycle is still a legal transfer.
- rst=1: all vld <= 0, count <= 0. Outputs after reset: out_vld=0, in_rdy=1, empty=1, full=0, count=0.
- Reset mid-stream discards all contents; there is no partial retention. rst has priority over flush.
- depth=1: a single registered stage. Chains degenerate to in_rdy = ~vld[0] | out_rdy.
- Data is never altered inside the block. Transfer order is strictly FIFO; no reordering or duplication.

Decomposition:
- Package sr_vr_pkg: function cnt_width(depth) returning $clog2(depth+1). No typedefs needed; width is per-instance.
- Sub-module vr_stage (one elastic stage: vld/data register with up/down valid-ready ports) is natural.
- Top = generate chain of depth vr_stage instances, plus count/flag logic.

Test Plan (width=8, depth=4 unless noted):
- Reset then stream 0x01..0x0A with in_vld=1, out_rdy=1 -> first out_vld at cycle 4 after the first accept. Outputs 0x01..0x0A back-to-back, in_rdy constantly 1, count stays 4 in steady state.
- Sparse input (0xA5, gap 3 cycles, 0x5A), out_rdy=1 -> each item appears exactly 4 cycles after its accept. out_vld=0 in between, no duplicates.
- out_rdy=0, push 0x10,0x11,0x12,0x13,0x14 -> first 4 accepted, then in_rdy=0 and full=1, count=4. Release out_rdy -> output order 0x10..0x14, with 0x14 accepted the same cycle the first output leaves.
- Full pipe, in_vld=1 and out_rdy=1 together -> one in, one out per cycle, count held at 4.
- Load 3 items, assert flush one cycle with in_vld=1 -> in_rdy=0 that cycle. Next cycle count=0, empty=1, out_vld=0, and no flushed item ever appears.
- depth=1, alternate out_rdy 1/0 with continuous input 0x00..0x07 -> every accepted value out once in order. in_rdy == ~out_vld | out_rdy every cycle. Then assert rst mid-stream -> next cycle out_vld=0, count=0.
